uart_key_encoder: RTL and testbench

Transmit-side counterpart of the UART key protocol. It watches the debounced player-control levels (P1, P2, game reset) and emits the one-byte key codes onto a UART transmitter through a valid/ready handshake, so a remote board's key decoder reproduces the same control state. It sits between the button/debounce logic and `uart_tx`.

---
 rtl/key_enc_pkg.sv | 54 +++++
 rtl/key_enc_rr_arb.sv | 48 ++++
 rtl/uart_key_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_uart_key_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_enc_pkg.sv
// Shared types and byte tables for the UART key encoder: source indices,
// press/release codes, selection digits and the packed input register layout.
package key_enc_pkg;

  localparam int NUM_SRC = 17;
  localparam int IDX_W   = $clog2(NUM_SRC);

  typedef enum logic [IDX_W-1:0] {
    SRC_P1_UP, SRC_P1_DOWN, SRC_P1_LEFT, SRC_P1_RIGHT, SRC_P1_FIRE, SRC_P1_SKILL,
    SRC_P1_SEL, SRC_P1_READY,
    SRC_P2_UP, SRC_P2_DOWN, SRC_P2_RIGHT, SRC_P2_LEFT, SRC_P2_FIRE, SRC_P2_SKILL,
    SRC_P2_SEL, SRC_P2_READY,
    SRC_GAME_RESET
  } src_e;

  typedef enum logic {ST_IDLE, ST_SEND} enc_state_e;

  // Sources re-sent by the periodic refresh: everything except the three events.
  localparam logic [NUM_SRC-1:0] REFRESH_MASK = 17'h07F7F;

  localparam logic [7:0] PRESS_CODE [NUM_SRC] = '{
    8'h77, 8'h73, 8'h61, 8'h64, 8'h68, 8'h6A, 8'h00, 8'h71,
    8'h69, 8'h6B, 8'h6C, 8'h6F, 8'h6E, 8'h6D, 8'h00, 8'h70, 8'h72
  };

  localparam logic [7:0] RELEASE_CODE [NUM_SRC] = '{
    8'h57, 8'h53, 8'h41, 8'h44, 8'h48, 8'h4A, 8'h00, 8'h71,
    8'h49, 8'h4B, 8'h4C, 8'h4F, 8'h4E, 8'h4D, 8'h00, 8'h70, 8'h72
  };

  localparam logic [7:0] P1_SEL_CODE [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
  localparam logic [7:0] P2_SEL_CODE [4] = '{8'h37, 8'h38, 8'h39, 8'h30};

  // Key bit order within a player field follows the source index order.
  typedef struct packed {
    logic       game_reset;
    logic       p2_ready;
    logic [1:0] p2_sel;
    logic [5:0] p2_key;
    logic       p1_ready;
    logic [1:0] p1_sel;
    logic [5:0] p1_key;
  } key_in_t;

  function automatic logic [7:0] src_code(input logic [IDX_W-1:0] idx, input logic [1:0] val);
    logic [7:0] code;
    if (idx == SRC_P1_SEL)      code = P1_SEL_CODE[val];
    else if (idx == SRC_P2_SEL) code = P2_SEL_CODE[val];
    else if (val[0])            code = PRESS_CODE[idx];
    else                        code = RELEASE_CODE[idx];
    return code;
  endfunction

endpackage

// File: rtl/key_enc_rr_arb.sv
// Round-robin arbiter over the encoder sources; combinational one-hot grant,
// search starts one past the registered last_grant, which moves only on upd_vld.
module key_enc_rr_arb
  import key_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] req,
  input  logic               upd_vld,
  input  logic [NUM_SRC-1:0] upd_gnt,
  output logic [NUM_SRC-1:0] gnt,
  output logic               any_req
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = IDX_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (upd_vld) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (upd_gnt[i]) last_grant_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) last_grant_q <= IDX_W'(NUM_SRC - 1);
    else       last_grant_q <= last_grant_d;
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_key_encoder.sv
// Encodes player-control level changes and confirm edges into one-byte key codes on a valid/ready
// byte stream; ~2 cycles input-to-valid, bytes held until tx_ready. Periodic resend: KEY_ENC_REFRESH_EN.
module uart_key_encoder
  import key_enc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p1_fire,
  input  logic       p1_skill,
  input  logic [1:0] p1_skill_sel,
  input  logic       p1_ready,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic       p2_fire,
  input  logic       p2_skill,
  input  logic [1:0] p2_skill_sel,
  input  logic       p2_ready,
  input  logic       game_reset_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  if (REFRESH_CYCLES < 2) begin : g_bad_refresh
    $error("REFRESH_CYCLES must be at least 2");
  end

  key_in_t            in_d, in_q;
  logic [2:0]         evt_d1_q, evt_d1_d, evt_rise;
  logic [11:0]        sent_state_q, sent_state_d;
  logic [1:0]         sent_sel1_q, sent_sel1_d, sent_sel2_q, sent_sel2_d;
  logic [2:0]         evt_pend_q, evt_pend_d;
  enc_state_e         state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [NUM_SRC-1:0] cur_gnt_q, cur_gnt_d;
  logic [1:0]         cur_val_q, cur_val_d;
  logic [NUM_SRC-1:0] pend, gnt, rfsh_flags;
  logic               any_req, accept;
  logic [IDX_W-1:0]   gnt_idx;
  logic [1:0]         src_val [NUM_SRC];
  logic [1:0]         gnt_val;

  always_comb begin
    in_d            = '0;
    in_d.p1_key     = {p1_skill, p1_fire, p1_right, p1_left, p1_down, p1_up};
    in_d.p1_sel     = p1_skill_sel;
    in_d.p1_ready   = p1_ready;
    in_d.p2_key     = {p2_skill, p2_fire, p2_left, p2_right, p2_down, p2_up};
    in_d.p2_sel     = p2_skill_sel;
    in_d.p2_ready   = p2_ready;
    in_d.game_reset = game_reset_req;
  end

  assign evt_d1_d = {in_q.game_reset, in_q.p2_ready, in_q.p1_ready};
  assign evt_rise = evt_d1_d & ~evt_d1_q;
  assign accept   = tx_valid_q & tx_ready;

`ifdef KEY_ENC_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  logic [CNT_W-1:0]   rfsh_cnt_q, rfsh_cnt_d;
  logic [NUM_SRC-1:0] rfsh_q, rfsh_d;
  logic               rfsh_wrap;

  // A wrap landing on the same edge as an accept re-arms that source.
  always_comb begin
    rfsh_wrap  = (rfsh_cnt_q == CNT_W'(REFRESH_CYCLES - 1));
    rfsh_cnt_d = rfsh_wrap ? '0 : rfsh_cnt_q + 1'b1;
    rfsh_d     = rfsh_q;
    if (accept)    rfsh_d = rfsh_d & ~cur_gnt_q;
    if (rfsh_wrap) rfsh_d = rfsh_d | REFRESH_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rfsh_cnt_q <= '0;
      rfsh_q     <= '0;
    end else begin
      rfsh_cnt_q <= rfsh_cnt_d;
      rfsh_q     <= rfsh_d;
    end
  end

  assign rfsh_flags = rfsh_q;
`else
  assign rfsh_flags = '0;
`endif

  always_comb begin
    pend        = '0;
    pend[5:0]   = in_q.p1_key ^ sent_state_q[5:0];
    pend[6]     = (in_q.p1_sel != sent_sel1_q);
    pend[7]     = evt_pend_q[0];
    pend[13:8]  = in_q.p2_key ^ sent_state_q[11:6];
    pend[14]    = (in_q.p2_sel != sent_sel2_q);
    pend[15]    = evt_pend_q[1];
    pend[16]    = evt_pend_q[2];
    pend        = pend | rfsh_flags;
  end

  key_enc_rr_arb u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (pend),
    .upd_vld (accept),
    .upd_gnt (cur_gnt_q),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // Value to be encoded per source: key level in bit 0, or the 2-bit selection.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_val[i] = 2'b01;
    for (int i = 0; i < 6; i++) begin
      src_val[i]     = {1'b0, in_q.p1_key[i]};
      src_val[i + 8] = {1'b0, in_q.p2_key[i]};
    end
    src_val[SRC_P1_SEL] = in_q.p1_sel;
    src_val[SRC_P2_SEL] = in_q.p2_sel;
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
    gnt_val = src_val[gnt_idx];
  end

  // A fresh edge on the accept cycle arrived after the grant, so it stays pending.
  always_comb begin
    evt_pend_d = evt_pend_q;
    if (accept) evt_pend_d = evt_pend_d & ~{cur_gnt_q[SRC_GAME_RESET], cur_gnt_q[SRC_P2_READY],
                                            cur_gnt_q[SRC_P1_READY]};
    evt_pend_d = evt_pend_d | evt_rise;
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    cur_gnt_d    = cur_gnt_q;
    cur_val_d    = cur_val_q;
    sent_state_d = sent_state_q;
    sent_sel1_d  = sent_sel1_q;
    sent_sel2_d  = sent_sel2_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          tx_data_d  = src_code(gnt_idx, gnt_val);
          tx_valid_d = 1'b1;
          cur_gnt_d  = gnt;
          cur_val_d  = gnt_val;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
          for (int i = 0; i < 6; i++) begin
            if (cur_gnt_q[i])     sent_state_d[i]     = cur_val_q[0];
            if (cur_gnt_q[i + 8]) sent_state_d[i + 6] = cur_val_q[0];
          end
          if (cur_gnt_q[SRC_P1_SEL]) sent_sel1_d = cur_val_q;
          if (cur_gnt_q[SRC_P2_SEL]) sent_sel2_d = cur_val_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_q         <= '0;
      evt_d1_q     <= '0;
      sent_state_q <= '0;
      sent_sel1_q  <= '0;
      sent_sel2_q  <= '0;
      evt_pend_q   <= '0;
      state_q      <= ST_IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      cur_gnt_q    <= '0;
      cur_val_q    <= '0;
    end else begin
      in_q         <= in_d;
      evt_d1_q     <= evt_d1_d;
      sent_state_q <= sent_state_d;
      sent_sel1_q  <= sent_sel1_d;
      sent_sel2_q  <= sent_sel2_d;
      evt_pend_q   <= evt_pend_d;
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cur_gnt_q    <= cur_gnt_d;
      cur_val_q    <= cur_val_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_key_encoder.sv
// Directed bench for uart_key_encoder: hand-computed key bytes, ordering and timing.
module tb_uart_key_encoder;

  logic       clk = 1'b0;
  logic       rstn;
  logic       p1_up, p1_down, p1_left, p1_right, p1_fire, p1_skill, p1_ready;
  logic [1:0] p1_skill_sel;
  logic       p2_up, p2_down, p2_left, p2_right, p2_fire, p2_skill, p2_ready;
  logic [1:0] p2_skill_sel;
  logic       game_reset_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] rx_q [$];

  uart_key_encoder #(.REFRESH_CYCLES(1000)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .p1_up          (p1_up),
    .p1_down        (p1_down),
    .p1_left        (p1_left),
    .p1_right       (p1_right),
    .p1_fire        (p1_fire),
    .p1_skill       (p1_skill),
    .p1_skill_sel   (p1_skill_sel),
    .p1_ready       (p1_ready),
    .p2_up          (p2_up),
    .p2_down        (p2_down),
    .p2_left        (p2_left),
    .p2_right       (p2_right),
    .p2_fire        (p2_fire),
    .p2_skill       (p2_skill),
    .p2_skill_sel   (p2_skill_sel),
    .p2_ready       (p2_ready),
    .game_reset_req (game_reset_req),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  // Each negedge with valid&ready precedes exactly one transfer edge.
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    p1_up = 0; p1_down = 0; p1_left = 0; p1_right = 0; p1_fire = 0; p1_skill = 0;
    p1_skill_sel = 0; p1_ready = 0;
    p2_up = 0; p2_down = 0; p2_left = 0; p2_right = 0; p2_fire = 0; p2_skill = 0;
    p2_skill_sel = 0; p2_ready = 0;
    game_reset_req = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    tx_ready = 0;
    rstn = 0;
    tick(2);
    rstn = 1;
    tick(2);
    rx_q.delete();
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check_val(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int c = 0;
    while (!tx_valid && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_val(tag, 32'(tx_valid), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    if (rx_q.size() == 0) check_val(tag, 32'hFFFF_FFFF, 32'(exp));
    else                  check_val(tag, 32'(rx_q.pop_front()), 32'(exp));
  endtask

`ifdef KEY_ENC_REFRESH_EN
  logic [7:0] rf_exp [14] = '{8'h44, 8'h48, 8'h4A, 8'h31, 8'h49, 8'h4B, 8'h4C,
                              8'h4F, 8'h4E, 8'h4D, 8'h37, 8'h57, 8'h53, 8'h61};
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    tx_ready = 0;
    rstn = 0;
    tick(1);
    check_val("rst_valid", 32'(tx_valid), 32'd0);
    check_val("rst_data", 32'(tx_data), 32'h00);
    tick(2);
    rstn = 1;
    tick(3);
    check_val("idle_valid", 32'(tx_valid), 32'd0);
    check_val("idle_quiet", 32'(rx_q.size()), 32'd0);

    // Latency: change before E1, in_q after E1, valid after E2, taken at E3.
    tx_ready = 1;
    p1_up = 1;
    tick(1);
    check_val("lat_e1_valid", 32'(tx_valid), 32'd0);
    tick(1);
    check_val("lat_e2_valid", 32'(tx_valid), 32'd1);
    check_val("lat_e2_data", 32'(tx_data), 32'h77);
    tick(1);
    check_val("lat_e3_valid", 32'(tx_valid), 32'd0);
    expect_byte("p1_up_press", 8'h77);
    p1_up = 0;
    wait_bytes("p1_up_rel_wait", 1, 20);
    expect_byte("p1_up_release", 8'h57);
    tick(10);
    check_val("t1_quiet", 32'(rx_q.size()), 32'd0);

    // Backpressure: fire pulse during a stalled 'd' nets to nothing.
    do_reset();
    p1_right = 1;
    wait_valid("d_valid", 20);
    check_val("d_data", 32'(tx_data), 32'h64);
    p1_fire = 1;
    tick(5);
    p1_fire = 0;
    tick(3);
    check_val("d_hold", 32'(tx_data), 32'h64);
    tx_ready = 1;
    tick(20);
    check_val("bp_count", 32'(rx_q.size()), 32'd1);
    expect_byte("bp_d", 8'h64);
    p1_right = 0;
    wait_bytes("bp_D_wait", 1, 20);
    expect_byte("bp_D", 8'h44);

    // Simultaneous P1/P2 up: round-robin from reset, then continuing from index 8.
    do_reset();
    tx_ready = 1;
    p1_up = 1;
    p2_up = 1;
    wait_bytes("rr_press_wait", 2, 30);
    expect_byte("rr_w", 8'h77);
    expect_byte("rr_i", 8'h69);
    tick(20);
    check_val("rr_quiet", 32'(rx_q.size()), 32'd0);
    p1_up = 0;
    p2_up = 0;
    wait_bytes("rr_rel_wait", 2, 30);
    expect_byte("rr_W", 8'h57);
    expect_byte("rr_I", 8'h49);

    // Selection digits.
    do_reset();
    tx_ready = 1;
    p1_skill_sel = 2;
    wait_bytes("sel1_wait", 1, 20);
    expect_byte("sel1_3", 8'h33);
    p2_skill_sel = 3;
    wait_bytes("sel2_wait", 1, 20);
    expect_byte("sel2_0", 8'h30);
    p1_skill_sel = 0;
    p2_skill_sel = 0;
    wait_bytes("sel_back_wait", 2, 30);
    expect_byte("sel1_1", 8'h31);
    expect_byte("sel2_7", 8'h37);

    // Events: a long level gives one byte; two edges while stalled merge.
    do_reset();
    tx_ready = 1;
    game_reset_req = 1;
    tick(10);
    game_reset_req = 0;
    tick(20);
    check_val("grst_count", 32'(rx_q.size()), 32'd1);
    expect_byte("grst_r", 8'h72);
    tx_ready = 0;
    p1_ready = 1; tick(1); p1_ready = 0; tick(3);
    p1_ready = 1; tick(1); p1_ready = 0; tick(3);
    tx_ready = 1;
    tick(20);
    check_val("merge_count", 32'(rx_q.size()), 32'd1);
    expect_byte("merge_q", 8'h71);

    // Key held across reset release produces a press.
    clr_inputs();
    tx_ready = 1;
    rstn = 0;
    p2_fire = 1;
    tick(2);
    rx_q.delete();
    rstn = 1;
    wait_bytes("held_wait", 1, 20);
    expect_byte("held_n", 8'h6E);
    p2_fire = 0;
    wait_bytes("held_rel_wait", 1, 20);
    expect_byte("held_N", 8'h4E);

    // Reset during SEND abandons the byte.
    do_reset();
    p1_down = 1;
    wait_valid("abort_valid", 20);
    rstn = 0;
    p1_down = 0;
    tick(1);
    check_val("abort_valid_drop", 32'(tx_valid), 32'd0);
    check_val("abort_data_clr", 32'(tx_data), 32'h00);
    rstn = 1;
    tx_ready = 1;
    tick(10);
    check_val("abort_quiet", 32'(rx_q.size()), 32'd0);

`ifdef KEY_ENC_REFRESH_EN
    do_reset();
    tx_ready = 1;
    p1_left = 1;
    wait_bytes("rf_first_wait", 1, 20);
    expect_byte("rf_first_a", 8'h61);
    wait_bytes("rf_burst_wait", 14, 1200);
    tick(30);
    check_val("rf_count", 32'(rx_q.size()), 32'd14);
    for (int i = 0; i < 14; i++) expect_byte($sformatf("rf_byte%0d", i), rf_exp[i]);
    tick(600);
    check_val("rf_quiet", 32'(rx_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
